// File: rtl/otter_fetch_unit_if.sv
// otter_fetch_unit_if
//   Bundles the fetch unit's connections to the PC register, instruction memory
//   and decoder.
//   master : fetch unit side (drives PC_WE, MEM_RDEN/MEM_ADDR, IR/IR_PC/IR_VALID)
//   slave  : environment side (drives PC_COUNT, FLUSH, MEM_READY, MEM_DVALID,
//            MEM_DOUT, IR_READY)
interface otter_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] PC_COUNT;
  logic            PC_WE;
  logic            FLUSH;
  logic            MEM_RDEN;
  logic [XLEN-1:0] MEM_ADDR;
  logic            MEM_READY;
  logic            MEM_DVALID;
  logic [XLEN-1:0] MEM_DOUT;
  logic [XLEN-1:0] IR;
  logic [XLEN-1:0] IR_PC;
  logic            IR_VALID;
  logic            IR_READY;

  modport master (
    input  PC_COUNT, FLUSH, MEM_READY, MEM_DVALID, MEM_DOUT, IR_READY,
    output PC_WE, MEM_RDEN, MEM_ADDR, IR, IR_PC, IR_VALID
  );

  modport slave (
    output PC_COUNT, FLUSH, MEM_READY, MEM_DVALID, MEM_DOUT, IR_READY,
    input  PC_WE, MEM_RDEN, MEM_ADDR, IR, IR_PC, IR_VALID
  );
endinterface

// File: rtl/otter_fetch_unit.sv
// otter_fetch_unit
//   Instruction fetch front end. Issues one instruction read at a time from
//   PC_COUNT, pulses PC_WE when a request is accepted, and buffers returned
//   words with their PC in a DEPTH-entry FIFO for the decoder. FLUSH empties
//   the buffer and discards any response still in flight.
//   clk   : rising-edge clock
//   RST_N : asynchronous active-low reset
//   bus   : otter_fetch_unit_if.master (PC, memory and decoder signals)
//
//   state | meaning
//   IDLE  | no request outstanding; waiting for a free buffer slot
//   REQ   | read request presented, waiting for MEM_READY
//   WAIT  | request accepted, waiting for MEM_DVALID
module otter_fetch_unit #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic               clk,
  input  logic               RST_N,
  otter_fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [XLEN-1:0] ir_mem [DEPTH];
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [XLEN-1:0] tag_q, ir_hold_q, ir_pc_hold_q;
  logic            drop_q, drop_d, tag_load;
  logic            push, pop, room, room_after, ir_valid;

  assign ir_valid   = (count_q != '0);
  assign room       = (count_q < CW'(DEPTH));
  // A response is kept only if no flush happened since (or during) its request.
  assign push       = (state_q == WAIT) && bus.MEM_DVALID && !drop_q && !bus.FLUSH;
  assign pop        = ir_valid && bus.IR_READY && !bus.FLUSH;
  assign room_after = (count_d < CW'(DEPTH));

  always_comb begin
    count_d = count_q;
    if (bus.FLUSH)          count_d = '0;
    else if (push && !pop)  count_d = count_q + CW'(1);
    else if (pop && !push)  count_d = count_q - CW'(1);
  end

  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    tag_load     = 1'b0;
    bus.MEM_RDEN = 1'b0;
    bus.PC_WE    = 1'b0;
    case (state_q)
      IDLE: if (room && !bus.FLUSH) state_d = REQ;
      REQ: begin
        bus.MEM_RDEN = 1'b1;
        if (bus.MEM_READY) begin
          tag_load  = 1'b1;
          drop_d    = bus.FLUSH;
          bus.PC_WE = !bus.FLUSH;
          state_d   = WAIT;
        end else if (bus.FLUSH) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (bus.FLUSH) drop_d = 1'b1;
        if (bus.MEM_DVALID) begin
          drop_d  = 1'b0;
          state_d = room_after ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      count_q      <= '0;
      drop_q       <= 1'b0;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ir_hold_q    <= '0;
      ir_pc_hold_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      if (tag_load) tag_q <= bus.PC_COUNT;
      if (bus.FLUSH) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      // Remember the head so IR/IR_PC keep their last value once the buffer empties.
      if (ir_valid) begin
        ir_hold_q    <= ir_mem[rd_ptr_q];
        ir_pc_hold_q <= pc_mem[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ir_mem[wr_ptr_q] <= bus.MEM_DOUT;
      pc_mem[wr_ptr_q] <= tag_q;
    end
  end

  assign bus.MEM_ADDR = (state_q == REQ) ? bus.PC_COUNT : '0;
  assign bus.IR_VALID = ir_valid;
  assign bus.IR       = ir_valid ? ir_mem[rd_ptr_q] : ir_hold_q;
  assign bus.IR_PC    = ir_valid ? pc_mem[rd_ptr_q] : ir_pc_hold_q;
endmodule

// File: tb/tb_otter_fetch_unit.sv
// tb_otter_fetch_unit
//   Directed bench for otter_fetch_unit: a PC register model, a memory responder
//   with programmable response delay, and a monitor logging decoder pops and
//   PC_WE pulses. The main sequence walks reset, straight-line fetch, stall,
//   backpressure, flush and reset-in-flight cases against hand-computed values.
module tb_otter_fetch_unit;
  logic clk;
  logic RST_N;
  logic [31:0] pc_q;
  logic [31:0] flush_pc;
  int dv_delay;
  int passed = 0;
  int total  = 0;
  int pc_we_cnt = 0;
  logic [31:0] pop_pc[$];
  logic [31:0] pop_ir[$];

  otter_fetch_unit_if #(.XLEN(32)) bus ();

  otter_fetch_unit #(.DEPTH(2), .XLEN(32)) dut (
    .clk   (clk),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N)            pc_q <= 32'h0;
    else if (bus.FLUSH)    pc_q <= flush_pc;
    else if (bus.PC_WE)    pc_q <= pc_q + 32'd4;
  end
  assign bus.PC_COUNT = pc_q;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00500093;
      32'h4:   return 32'h00A00113;
      32'h8:   return 32'h002081B3;
      default: return {16'hA5A5, a[15:0]};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wait_pcwe(input int n);
    int k = 0;
    while (pc_we_cnt < n && k < 60) begin
      tick();
      k++;
    end
    total++;
    assert (pc_we_cnt >= n) passed++;
    else $error("FAIL wait_pcwe observed=%0d expected=%0d", pc_we_cnt, n);
  endtask

  task automatic wait_pops(input int n);
    int k = 0;
    while (pop_pc.size() < n && k < 60) begin
      tick();
      k++;
    end
    total++;
    assert (pop_pc.size() >= n) passed++;
    else $error("FAIL wait_pops observed=%0d expected=%0d", pop_pc.size(), n);
  endtask

  // Memory responder: one data beat dv_delay cycles after each accepted request.
  initial begin
    logic [31:0] a;
    int d;
    bus.MEM_DVALID = 1'b0;
    bus.MEM_DOUT   = 32'h0;
    forever begin
      @(negedge clk);
      if (RST_N && bus.MEM_RDEN && bus.MEM_READY) begin
        a = bus.MEM_ADDR;
        d = dv_delay;
        @(posedge clk); #1;
        repeat (d - 1) begin @(posedge clk); #1; end
        bus.MEM_DVALID = 1'b1;
        bus.MEM_DOUT   = mem_word(a);
        @(posedge clk); #1;
        bus.MEM_DVALID = 1'b0;
      end
    end
  end

  // Monitor: decoder pops and PC_WE pulses, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (RST_N) begin
        if (bus.PC_WE) pc_we_cnt++;
        if (bus.IR_VALID && bus.IR_READY && !bus.FLUSH) begin
          pop_pc.push_back(bus.IR_PC);
          pop_ir.push_back(bus.IR);
        end
      end
    end
  end

  initial begin
    RST_N         = 1'b0;
    bus.FLUSH     = 1'b0;
    bus.MEM_READY = 1'b0;
    bus.IR_READY  = 1'b0;
    flush_pc      = 32'h0;
    dv_delay      = 1;

    // Reset values
    #3;
    chk("rst_pc_we",    bus.PC_WE,    0);
    chk("rst_rden",     bus.MEM_RDEN, 0);
    chk("rst_addr",     bus.MEM_ADDR, 0);
    chk("rst_ir_valid", bus.IR_VALID, 0);
    chk("rst_ir",       bus.IR,       0);
    chk("rst_ir_pc",    bus.IR_PC,    0);
    #9 RST_N = 1'b1;
    tick();
    chk("post_rst_rden", bus.MEM_RDEN, 1);
    chk("post_rst_addr", bus.MEM_ADDR, 32'h0);

    // Straight-line fetch, zero-wait memory
    bus.MEM_READY = 1'b1;
    bus.IR_READY  = 1'b1;
    wait_pcwe(3);
    bus.MEM_READY = 1'b0;
    wait_pops(3);
    chk("sl_pc0", pop_pc[0], 32'h0);
    chk("sl_ir0", pop_ir[0], 32'h00500093);
    chk("sl_pc1", pop_pc[1], 32'h4);
    chk("sl_ir1", pop_ir[1], 32'h00A00113);
    chk("sl_pc2", pop_pc[2], 32'h8);
    chk("sl_ir2", pop_ir[2], 32'h002081B3);
    chk("sl_pcwe_cnt", pc_we_cnt, 3);

    // Memory stall: request held stable, no PC advance
    repeat (3) begin
      tick();
      chk("stall_rden",  bus.MEM_RDEN, 1);
      chk("stall_addr",  bus.MEM_ADDR, 32'hC);
      chk("stall_pc_we", bus.PC_WE,    0);
    end
    chk("stall_pcwe_cnt", pc_we_cnt, 3);

    // Backpressure: buffer fills to two entries, then fetch stops
    bus.IR_READY  = 1'b0;
    bus.MEM_READY = 1'b1;
    repeat (10) tick();
    chk("bp_ir_valid", bus.IR_VALID, 1);
    chk("bp_ir_pc",    bus.IR_PC,    32'hC);
    chk("bp_ir",       bus.IR,       32'hA5A5000C);
    chk("bp_rden",     bus.MEM_RDEN, 0);
    chk("bp_pc_we",    bus.PC_WE,    0);
    chk("bp_pcwe_cnt", pc_we_cnt,    5);
    chk("bp_pops",     pop_pc.size(), 3);
    bus.IR_READY = 1'b1;
    wait_pops(5);
    chk("bp_pc3", pop_pc[3], 32'hC);
    chk("bp_pc4", pop_pc[4], 32'h10);
    wait_pcwe(6);
    bus.MEM_READY = 1'b0;
    wait_pops(6);
    chk("bp_pc5", pop_pc[5], 32'h14);

    // Flush while waiting for data, with one entry buffered
    bus.IR_READY  = 1'b0;
    bus.MEM_READY = 1'b1;
    wait_pcwe(7);
    bus.MEM_READY = 1'b0;
    repeat (3) tick();
    chk("fl_pre_valid", bus.IR_VALID, 1);
    chk("fl_pre_ir_pc", bus.IR_PC,    32'h18);
    chk("fl_pre_addr",  bus.MEM_ADDR, 32'h1C);
    dv_delay      = 4;
    bus.MEM_READY = 1'b1;
    tick();
    bus.MEM_READY = 1'b0;
    bus.FLUSH     = 1'b1;
    flush_pc      = 32'h100;
    chk("fl_wait_rden", bus.MEM_RDEN, 0);
    tick();
    bus.FLUSH = 1'b0;
    chk("fl_empty",    bus.IR_VALID, 0);
    chk("fl_pcwe_cnt", pc_we_cnt,    8);
    repeat (5) tick();
    chk("fl_dropped_valid", bus.IR_VALID, 0);
    chk("fl_resume_rden",   bus.MEM_RDEN, 1);
    chk("fl_resume_addr",   bus.MEM_ADDR, 32'h100);
    dv_delay      = 1;
    bus.IR_READY  = 1'b1;
    bus.MEM_READY = 1'b1;
    wait_pcwe(9);
    bus.MEM_READY = 1'b0;
    wait_pops(7);
    chk("fl_next_pc", pop_pc[6], 32'h100);
    chk("fl_next_ir", pop_ir[6], 32'hA5A50100);

    // FLUSH together with MEM_READY
    bus.MEM_READY = 1'b1;
    bus.FLUSH     = 1'b1;
    flush_pc      = 32'h200;
    #2;
    chk("fr_pc_we", bus.PC_WE,    0);
    chk("fr_rden",  bus.MEM_RDEN, 1);
    tick();
    bus.FLUSH     = 1'b0;
    bus.MEM_READY = 1'b0;
    tick();
    chk("fr_no_push",  bus.IR_VALID, 0);
    chk("fr_rden2",    bus.MEM_RDEN, 1);
    chk("fr_addr",     bus.MEM_ADDR, 32'h200);
    chk("fr_pcwe_cnt", pc_we_cnt,    9);

    // FLUSH together with MEM_DVALID
    dv_delay      = 2;
    bus.MEM_READY = 1'b1;
    tick();
    bus.MEM_READY = 1'b0;
    tick();
    bus.FLUSH = 1'b1;
    flush_pc  = 32'h300;
    #2;
    chk("fd_dvalid_seen", bus.MEM_DVALID, 1);
    tick();
    bus.FLUSH = 1'b0;
    chk("fd_no_push",  bus.IR_VALID, 0);
    chk("fd_rden",     bus.MEM_RDEN, 1);
    chk("fd_addr",     bus.MEM_ADDR, 32'h300);
    chk("fd_pcwe_cnt", pc_we_cnt,    10);
    dv_delay      = 1;
    bus.MEM_READY = 1'b1;
    wait_pcwe(11);
    bus.MEM_READY = 1'b0;
    wait_pops(8);
    chk("fd_next_pc", pop_pc[7], 32'h300);
    chk("fd_next_ir", pop_ir[7], 32'hA5A50300);

    // Reset in the middle of a transfer; the late response must be ignored
    tick();
    bus.FLUSH = 1'b1;
    flush_pc  = 32'h40;
    tick();
    bus.FLUSH = 1'b0;
    tick();
    chk("rw_rden", bus.MEM_RDEN, 1);
    chk("rw_addr", bus.MEM_ADDR, 32'h40);
    dv_delay      = 6;
    bus.MEM_READY = 1'b1;
    tick();
    bus.MEM_READY = 1'b0;
    tick();
    #2 RST_N = 1'b0;
    #1;
    chk("rw_pc_we",    bus.PC_WE,    0);
    chk("rw_rden0",    bus.MEM_RDEN, 0);
    chk("rw_addr0",    bus.MEM_ADDR, 0);
    chk("rw_ir_valid", bus.IR_VALID, 0);
    chk("rw_ir",       bus.IR,       0);
    chk("rw_ir_pc",    bus.IR_PC,    0);
    #3 RST_N = 1'b1;
    tick();
    chk("rw_req_rden", bus.MEM_RDEN, 1);
    chk("rw_req_addr", bus.MEM_ADDR, 32'h0);
    repeat (6) tick();
    chk("rw_late_ignored", bus.IR_VALID, 0);
    chk("rw_still_req",    bus.MEM_RDEN, 1);
    chk("rw_still_addr",   bus.MEM_ADDR, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
